apb_slave_regfile: RTL and testbench

//  - APB completer: answers transfers driven by apb_master and fronts a bank of NUM_REGS x WIDTH

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_regfile.sv | 61 ++++++
 rtl/apb_slave_regfile.sv | 133 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types and helpers for the APB completer register file.
//   - apb_slv_state_t   : completer FSM states (IDLE, ACCESS)
//   - apb_addr_in_range : true when a word address selects an implemented register
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_t;

   // Callers zero-extend their address to 32 bits before calling.
   function automatic logic apb_addr_in_range(input logic [31:0] addr,
                                              input int unsigned num_regs);
      return addr < num_regs;
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// -----------------------------------------------------------------------------
// apb_regfile
//   NUM_REGS x WIDTH register array with one synchronous write port and one
//   combinational read port. Addresses outside 0..NUM_REGS-1 hit nothing:
//   writes are dropped and reads return 0.
// Ports
//   clk, rst  : clock, asynchronous active-high reset (clears every register)
//   we        : write enable
//   wr_addr   : write word address
//   wr_data   : write data
//   rd_addr   : read word address
//   rd_data   : read data (combinational)
//   reg_q     : flattened register contents, reg i at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module apb_regfile #(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [WIDTH-1:0]          wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [WIDTH-1:0]          rd_addr,
   output logic [WIDTH-1:0]          rd_data,
   output logic [WIDTH*NUM_REGS-1:0] reg_q
);

   // Packed so that reg i lands at [i*WIDTH +: WIDTH] of the flat view.
   logic [NUM_REGS-1:0][WIDTH-1:0] regs_q;
   logic [NUM_REGS-1:0][WIDTH-1:0] regs_d;

   // Decoding with an equality per entry keeps out-of-range addresses from
   // ever indexing the array.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
      regs_d  = regs_q;
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (we && (wr_addr == WIDTH'(i))) begin
            regs_d[i] = wr_data;
         end
         if (rd_addr == WIDTH'(i)) begin
            rd_data = regs_q[i];
         end
      end
   end

   // NOTE: this array is plain flops, not RAM; reset clears it because software relies on zeroed registers after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         regs_q <= regs_d;
      end
   end

   assign reg_q = regs_q;

endmodule

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
//   APB completer fronting a NUM_REGS x WIDTH register bank, inserting
//   WAIT_CYCLES PREADY-low cycles in each access phase.
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   PSEL      : completer select
//   PENABLE   : access-phase strobe
//   PWRITE    : 1 = write, 0 = read
//   PADDR     : register word address
//   PWDATA    : write data
//   PRDATA    : read data, nonzero only in the PREADY cycle of a read
//   PREADY    : transfer-complete strobe
//   PSLVERR   : error response for out-of-range addresses
//   reg_q     : flattened register contents, reg i at [i*WIDTH +: WIDTH]
// Configuration
//   APB_SLV_PSLVERR_EN : when defined, out-of-range transfers complete with
//                        PSLVERR=1; otherwise PSLVERR is tied 0.
// -----------------------------------------------------------------------------
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [WIDTH-1:0]          PADDR,
   input  logic [WIDTH-1:0]          PWDATA,
   output logic [WIDTH-1:0]          PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [WIDTH*NUM_REGS-1:0] reg_q
);

   // At least one bit so WAIT_CYCLES=0 still yields a legal vector.
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   apb_slv_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] addr_q,  addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             write_q, write_d;

   logic             pready;
   logic             in_range;
   logic             reg_we;
   logic [WIDTH-1:0] rd_data;

   // Next-state logic. The transfer fields are captured in the setup phase
   // and held, so bus changes during ACCESS have no effect.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      pready  = 1'b0;
      case (state_q)
         IDLE: begin
            // PENABLE already high here is a protocol violation and is ignored.
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               wdata_d = PWDATA;
               write_d = PWRITE;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               // Master abandoned the transfer: no completion, no write.
               state_d = IDLE;
            end else if (PENABLE) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  pready  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

   assign in_range = apb_addr_in_range(32'(addr_q), NUM_REGS);
   assign reg_we   = pready && write_q && in_range;

   apb_regfile #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (reg_we),
      .wr_addr (addr_q),
      .wr_data (wdata_q),
      .rd_addr (addr_q),
      .rd_data (rd_data),
      .reg_q   (reg_q)
   );

   // PREADY derives from flopped state, so reset drops it without waiting for a clock.
   assign PREADY = pready;
   assign PRDATA = (pready && !write_q && in_range) ? rd_data : '0;

`ifdef APB_SLV_PSLVERR_EN
   assign PSLVERR = pready && !in_range;
`else
   assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
//   Two completers share one set of bus drivers: instance 0 with one wait
//   state, instance 1 with zero wait states. PSEL reaches only the selected
//   instance. A per-instance array of register values is the reference.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

   localparam int W = 8;
   localparam int N = 16;
`ifdef APB_SLV_PSLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         psel, penable, pwrite;
   logic [W-1:0] paddr, pwdata;
   int           sel;

   logic         psel0, psel1;
   logic [W-1:0] prdata0, prdata1, prdata;
   logic         pready0, pready1, pready;
   logic         pslverr0, pslverr1, pslverr;
   logic [W*N-1:0] regq0, regq1;
   logic         pready_other;

   logic [W-1:0] mem [2][N];
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   assign psel0        = psel && (sel == 0);
   assign psel1        = psel && (sel == 1);
   assign prdata       = (sel == 1) ? prdata1  : prdata0;
   assign pready       = (sel == 1) ? pready1  : pready0;
   assign pslverr      = (sel == 1) ? pslverr1 : pslverr0;
   assign pready_other = (sel == 1) ? pready0  : pready1;

   apb_slave_regfile #(.WIDTH(W), .NUM_REGS(N), .WAIT_CYCLES(1)) u_dut0 (
      .clk     (clk),
      .rst     (rst),
      .PSEL    (psel0),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PRDATA  (prdata0),
      .PREADY  (pready0),
      .PSLVERR (pslverr0),
      .reg_q   (regq0)
   );

   apb_slave_regfile #(.WIDTH(W), .NUM_REGS(N), .WAIT_CYCLES(0)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .PSEL    (psel1),
      .PENABLE (penable),
      .PWRITE  (pwrite),
      .PADDR   (paddr),
      .PWDATA  (pwdata),
      .PRDATA  (prdata1),
      .PREADY  (pready1),
      .PSLVERR (pslverr1),
      .reg_q   (regq1)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W*N-1:0] model_flat(input int k);
      logic [W*N-1:0] flat;
      for (int i = 0; i < N; i++) flat[i*W +: W] = mem[k][i];
      return flat;
   endfunction

   function automatic int wait_of(input int k);
      return (k == 0) ? 1 : 0;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < N; i++) mem[k][i] = '0;
   endtask

   task automatic check_regs();
      check("reg_q0", regq0, model_flat(0));
      check("reg_q1", regq1, model_flat(1));
   endtask

   task automatic check_outs(input string tag, input bit exp_ready,
                             input logic [W-1:0] exp_rdata, input bit exp_err);
      check({tag, "_pready"},  pready,       exp_ready);
      check({tag, "_prdata"},  prdata,       exp_rdata);
      check({tag, "_pslverr"}, pslverr,      exp_err);
      check({tag, "_other"},   pready_other, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         psel = 1'b0; penable = 1'b0;
         #1;
         check_outs("idle", 1'b0, '0, 1'b0);
         check_regs();
      end
   endtask

   // One complete transfer; returns in its PREADY cycle so a following call
   // lands its setup phase back-to-back. Bus fields are scrambled in ACCESS.
   task automatic xfer(input int k, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
      int               wt  = wait_of(k);
      bit               oor = (int'(a) >= N);
      logic [W-1:0]     exp_rd;
      @(negedge clk);
      sel = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      #1;
      check_outs("setup", 1'b0, '0, 1'b0);
      check_regs();
      for (int c = 0; c <= wt; c++) begin
         @(negedge clk);
         penable = 1'b1; paddr = W'($urandom); pwdata = W'($urandom);
         #1;
         if (c == wt) begin
            exp_rd = (!wr && !oor) ? mem[k][int'(a)] : '0;
            check_outs(wr ? "wr_done" : "rd_done", 1'b1, exp_rd, ERR_EN && oor);
            if (wr && !oor) mem[k][int'(a)] = d;
         end else begin
            check_outs("wait", 1'b0, '0, 1'b0);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; sel = 0;
      clear_model();

      // Reset state of both instances.
      repeat (2) @(negedge clk);
      #1;
      check("rst_pready0", pready0, 1'b0);
      check("rst_pready1", pready1, 1'b0);
      check("rst_prdata0", prdata0, '0);
      check("rst_prdata1", prdata1, '0);
      check("rst_pslverr0", pslverr0, 1'b0);
      check_regs();
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // One-wait write then read of reg 3; idles confirm PRDATA returns to 0.
      xfer(0, 1'b1, 8'd3, 8'hA5);
      idle(1);
      xfer(0, 1'b0, 8'd3, 8'h00);
      idle(2);

      // Zero-wait back-to-back writes, then read both back.
      xfer(1, 1'b1, 8'd0, 8'h11);
      xfer(1, 1'b1, 8'd1, 8'h22);
      xfer(1, 1'b0, 8'd0, 8'h00);
      xfer(1, 1'b0, 8'd1, 8'h00);
      idle(1);

      // Out-of-range write and read on both instances.
      xfer(0, 1'b1, 8'd20, 8'h77);
      xfer(0, 1'b0, 8'd20, 8'h00);
      xfer(1, 1'b1, 8'd20, 8'h66);
      xfer(1, 1'b0, 8'd20, 8'h00);
      idle(1);

      // PSEL dropped during the wait state of a write to reg 2.
      @(negedge clk);
      sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 8'h5A;
      #1;
      check_outs("ab_setup", 1'b0, '0, 1'b0);
      @(negedge clk);
      penable = 1'b1;
      #1;
      check_outs("ab_wait", 1'b0, '0, 1'b0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      #1;
      check_outs("ab_drop", 1'b0, '0, 1'b0);
      idle(2);
      xfer(0, 1'b0, 8'd2, 8'h00);
      xfer(0, 1'b1, 8'd2, 8'h3C);
      idle(1);

      // PENABLE high while IDLE is ignored; the next setup is still served.
      @(negedge clk);
      sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd4; pwdata = 8'hEE;
      #1;
      check_outs("viol", 1'b0, '0, 1'b0);
      @(negedge clk);
      #1;
      check_outs("viol2", 1'b0, '0, 1'b0);
      xfer(0, 1'b1, 8'd5, 8'h99);
      idle(1);

      // Randomized mix of reads/writes, in and out of range, both instances.
      repeat (80) begin
         int              k  = int'($urandom_range(0, 1));
         bit              wr = 1'($urandom_range(0, 1));
         logic [W-1:0]    a  = ($urandom_range(0, 4) == 0) ? W'($urandom_range(N, 255))
                                                          : W'($urandom_range(0, N - 1));
         xfer(k, wr, a, W'($urandom));
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(1);

      // Reset asserted in the PREADY cycle of a one-wait write.
      @(negedge clk);
      sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd6; pwdata = 8'hC3;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      #1;
      check("pre_rst_pready", pready0, 1'b1);
      rst = 1'b1;
      #1;
      clear_model();
      check("rst_async_pready", pready0, 1'b0);
      check_regs();
      @(negedge clk);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      idle(1);
      xfer(0, 1'b1, 8'd6, 8'h81);
      xfer(0, 1'b0, 8'd6, 8'h00);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
